online_sd_adder_pipe: RTL and testbench
=======================================

Name: online_sd_adder_pipe

Overview:
- Digit-serial, MSD-first (online) signed-digit adder/subtractor with registered output and valid/ready handshakes.
- Generalises the parallel radix-4 signed-digit adder to a parametrised radix 2^(radix_bits-1), a parametrised frame length and a per-frame add/sub mode.
- Online delay is 1 digit, so it sits between online multiplier/divider stages in the high-radix datapath.
- Digits use sign-magnitude encoding: MSB is the sign, the lower radix_bits-1 bits are the magnitude. The digit set is {-(r-1)..r-1}.

Parameters:
no_of_digits, 8, input digits per frame (>=1); output frame is no_of_digits+1 digits
radix_bits, 3, digit width; radix r = 2^(radix_bits-1) (default r=4)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input digit pair valid
in_ready  out  1  block accepts the input digit pair this cycle
din1  in  radix_bits  operand A digit, sign-magnitude
din2  in  radix_bits  operand B digit, sign-magnitude
cin  in  1  LSD carry-in; sampled only with the first digit of a frame
sub  in  1  1 = A-B; sampled only with the first digit of a frame
out_valid  out  1  output digit valid
out_ready  in  1  downstream accepts the output digit
dout  out  radix_bits  result digit, sign-magnitude
out_first  out  1  marks the leading transfer digit t0
out_last  out  1  marks the final digit of the output frame

Behaviour:
- Reset is synchronous and active-low on rst_n, single clock clk. On reset: state=IDLE, digit counter=0, out_valid=0, dout=0, out_first=0, out_last=0, and all latched w, cin and sub cleared. Asserting reset mid-frame discards the partial frame with no further output.
- Handshakes: a transfer occurs when valid&&ready. The output slot is free when !out_valid || out_ready. in_ready = slot_free in IDLE/RUN, and 0 in FLUSH. in_ready does not depend on in_valid.
- Per accepted digit j:
  - bB = sub ? -b : b, applied by sign-bit flip.
  - s = a + bB.
  - If s >= r-1: t=+1, w = s-r. If s <= -(r-1): t=-1, w = s+r. Otherwise t=0, w = s.
  - This guarantees |w| <= r-2 and |w+t| <= r-1.
- FSM:
  - IDLE: on accept of digit 0, latch cin, sub and w0. Next cycle output dout=t0 with out_first=1. Go to RUN, or to FLUSH when no_of_digits==1.
  - RUN: on accept of digit j, output dout = w(j-1)+t(j) and latch wj. When j==no_of_digits-1, go to FLUSH.
  - FLUSH: when the slot is free, output dout = w(N-1)+cin with out_last=1. Go to IDLE.
- Latency and throughput:
  - Output is registered; an accepted input appears on dout 1 cycle later.
  - Without backpressure, one frame takes N+1 cycles.
  - Back-to-back frames lose one input cycle, to FLUSH.
- Output rules:
  - While out_valid=1 && out_ready=0, dout, out_first and out_last hold stable.
  - Zero is always emitted as +0 (sign bit 0).
  - Input -0 is treated as value 0.
- Arithmetic uses signed internals wide enough for ±2(r-1); no truncation.
- Value identity: sum over k of dout_k * r^(N-k) equals A ± B + cin, where k=0 is t0.

Optional Feature:
- Macro: ONLINE_ADD_NEGZERO_CHK_EN.
- When defined, adds output port frame_err (1 bit). It goes sticky-high within a frame if any accepted din1/din2 digit is -0 (sign=1, magnitude=0). It is reported coincident with the out_last digit (frame_err=1 only on that beat). It clears on the next frame's first accept and on reset. Arithmetic is unchanged.
- Without the macro: no frame_err port and no checking logic.

Test Plan:
- r=4, N=4, A=[3,3,3,3] (255), B=[1,0,0,0] (64), cin=0, sub=0 -> dout 1,1,0,0,-1 (3'b001,3'b001,0,0,3'b101) = 319. out_first on beat 0, out_last on beat 4.
- A=[-3,-3,0,0], B=[-3,0,0,0] -> dout -1,-3,+1,0,0 = -432.
- A=B=[1,0,0,0], sub=1 -> five +0 digits, all 3'b000. Also A=B=0, cin=1 -> 0,0,0,0,+1.
- Backpressure: hold out_ready=0 for 3 cycles mid-frame -> in_ready=0, dout stable. Result is identical to the no-stall case; back-to-back frames show exactly one FLUSH bubble.
- Reset: rst_n=0 after 2 accepted digits -> out_valid=0 next cycle. A following frame computes correctly with cin and sub re-sampled.
- With ONLINE_ADD_NEGZERO_CHK_EN: din2=3'b100 in digit 2 -> frame_err=1 only with out_last. The next clean frame gives frame_err=0.

Source files
------------

// File: rtl/online_sd_adder_pipe.sv
// MSD-first online signed-digit adder/subtractor, radix 2^(radix_bits-1), online delay of one digit.
// Define ONLINE_ADD_NEGZERO_CHK_EN to add the frame_err output flagging -0 input digits.
module online_sd_adder_pipe #(
  parameter int no_of_digits = 8,
  parameter int radix_bits   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [radix_bits-1:0] din1,
  input  logic [radix_bits-1:0] din2,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [radix_bits-1:0] dout,
  output logic                  out_first,
  output logic                  out_last
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int mw = radix_bits - 1;
  localparam int iw = radix_bits + 2;
  localparam int r  = 2 ** mw;
  localparam int cw = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;

  localparam logic signed [iw-1:0] rval     = iw'(r);
  localparam logic signed [iw-1:0] rm1      = iw'(r - 1);
  localparam logic signed [iw-1:0] one      = iw'(1);
  localparam logic [cw-1:0]        last_idx = cw'(no_of_digits - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Sign-magnitude digit to signed integer; flip negates by inverting the sign bit.
  function automatic logic signed [iw-1:0] to_int(input logic [radix_bits-1:0] d,
                                                  input logic flip);
    logic signed [iw-1:0] m;
    m = '0;
    m[mw-1:0] = d[mw-1:0];
    return (d[radix_bits-1] ^ flip) ? -m : m;
  endfunction

  // Signed integer back to sign-magnitude; zero always leaves as +0.
  function automatic logic [radix_bits-1:0] to_sm(input logic signed [iw-1:0] v);
    logic [mw-1:0] mag;
    mag = v[iw-1] ? mw'(-v) : mw'(v);
    return {v[iw-1], mag};
  endfunction

  state_t               state, state_nx;
  logic [cw-1:0]        cnt;
  logic signed [iw-1:0] w_q;
  logic                 cin_q, sub_q;
  logic                 slot_free, accept, sub_eff;
  logic signed [iw-1:0] a_v, b_v, s_v, t_v, w_v, cin_ext;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state != FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;
  assign cin_ext   = {{(iw-1){1'b0}}, cin_q};

  // Digit-level transfer/interim split: t carries into the previous position, w stays here.
  always_comb begin
    sub_eff = (state == IDLE) ? sub : sub_q;
    a_v = to_int(din1, 1'b0);
    b_v = to_int(din2, sub_eff);
    s_v = a_v + b_v;
    t_v = '0;
    w_v = s_v;
    if (s_v >= rm1) begin
      t_v = one;
      w_v = s_v - rval;
    end else if (s_v <= -rm1) begin
      t_v = -one;
      w_v = s_v + rval;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (no_of_digits == 1) ? FLUSH : RUN;
      RUN:     if (accept && cnt == last_idx) state_nx = FLUSH;
      FLUSH:   if (slot_free) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ONLINE_ADD_NEGZERO_CHK_EN
  localparam logic [radix_bits-1:0] negzero = {1'b1, {mw{1'b0}}};
  logic err_acc, nz;
  assign nz = (din1 == negzero) || (din2 == negzero);
`endif

  // Output register: a free slot empties unless a new digit is produced in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      w_q       <= '0;
      cin_q     <= 1'b0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      dout      <= '0;
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
      err_acc   <= 1'b0;
      frame_err <= 1'b0;
`endif
    end else begin
      if (slot_free) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
        frame_err <= 1'b0;
`endif
      end
      case (state)
        IDLE: if (accept) begin
          cin_q     <= cin;
          sub_q     <= sub;
          w_q       <= w_v;
          cnt       <= cw'(1);
          dout      <= to_sm(t_v);
          out_valid <= 1'b1;
          out_first <= 1'b1;
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
          err_acc   <= nz;
`endif
        end
        RUN: if (accept) begin
          w_q       <= w_v;
          cnt       <= cnt + 1'b1;
          dout      <= to_sm(w_q + t_v);
          out_valid <= 1'b1;
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
          err_acc   <= err_acc | nz;
`endif
        end
        FLUSH: if (slot_free) begin
          cnt       <= '0;
          dout      <= to_sm(w_q + cin_ext);
          out_valid <= 1'b1;
          out_last  <= 1'b1;
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
          frame_err <= err_acc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_online_sd_adder_pipe.sv
// Self-checking bench for online_sd_adder_pipe (r=4, N=4): directed vectors plus random frames
// against a digit-rule and whole-number reference model.
module tb_online_sd_adder_pipe;
  localparam int N  = 4;
  localparam int RB = 3;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RB-1:0] din1 = '0;
  logic [RB-1:0] din2 = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RB-1:0] dout;
  logic          out_first;
  logic          out_last;
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
  logic          frame_err;
`endif

  online_sd_adder_pipe #(.no_of_digits(N), .radix_bits(RB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din2(din2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_first(out_first), .out_last(out_last)
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     digit;
    bit     first;
    bit     last;
    bit     err;
    longint total;
  } exp_t;

  exp_t   expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     readyMode = 0;
  int     curA[N];
  int     curB[N];
  bit     negA[N];
  bit     negB[N];

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [RB-1:0] encDigit(input int v, input bit negz);
    logic [RB-1:0] d;
    if (v < 0)                d = {1'b1, 2'(-v)};
    else if (v == 0 && negz)  d = {1'b1, 2'b00};
    else                      d = {1'b0, 2'(v)};
    return d;
  endfunction

  function automatic int decDigit(input logic [RB-1:0] d);
    int m;
    m = int'(d[RB-2:0]);
    return d[RB-1] ? -m : m;
  endfunction

  // Reference: per-digit transfer rule for the expected digit stream, plain integer sum for the value.
  task automatic buildExpected(input bit cinV, input bit subV);
    int t[N];
    int w[N];
    int s;
    longint av, bv, tot;
    bit err;
    av = 0; bv = 0; err = 0;
    for (int j = 0; j < N; j++) begin
      av = av * R + curA[j];
      bv = bv * R + curB[j];
      s  = curA[j] + (subV ? -curB[j] : curB[j]);
      if (s >= R - 1)         begin t[j] = 1;  w[j] = s - R; end
      else if (s <= -(R - 1)) begin t[j] = -1; w[j] = s + R; end
      else                    begin t[j] = 0;  w[j] = s;     end
      err |= (curA[j] == 0 && negA[j]) || (curB[j] == 0 && negB[j]);
    end
    tot = (subV ? av - bv : av + bv) + cinV;
    expQ.push_back('{t[0], 1'b1, 1'b0, 1'b0, tot});
    for (int j = 1; j < N; j++) expQ.push_back('{w[j-1] + t[j], 1'b0, 1'b0, 1'b0, tot});
    expQ.push_back('{w[N-1] + cinV, 1'b0, 1'b1, err, tot});
  endtask

  // Drives the first 'count' digits of curA/curB; cin/sub get junk after digit 0.
  task automatic applyStimulus(input int count, input bit cinV, input bit subV,
                               input bit gaps, output int waits);
    waits = 0;
    for (int j = 0; j < count; j++) begin
      in_valid = 1'b1;
      din1 = encDigit(curA[j], negA[j]);
      din2 = encDigit(curB[j], negB[j]);
      cin  = (j == 0) ? cinV : 1'($urandom);
      sub  = (j == 0) ? subV : 1'($urandom);
      forever begin
        @(negedge clk);
        if (in_ready) break;
        waits++;
        if (waits > 200) begin
          checkOutput("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic setFrame(input int a[N], input int b[N]);
    for (int j = 0; j < N; j++) begin
      curA[j] = a[j]; curB[j] = b[j]; negA[j] = 0; negB[j] = 0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard compare, value identity and stall stability.
  longint        accum = 0;
  bit            prevStall = 0;
  logic [RB-1:0] prevDout;
  logic          prevFirst, prevLast;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prevStall = 0;
    else begin
      if (out_valid && !out_ready) checkOutput("in_ready_stall", in_ready, 0);
      if (prevStall) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_dout", dout, prevDout);
        checkOutput("hold_first", out_first, prevFirst);
        checkOutput("hold_last", out_last, prevLast);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) checkOutput("unexpected_out", 1, 0);
        else begin
          e = expQ.pop_front();
          checkOutput("dout", dout, encDigit(e.digit, 0));
          checkOutput("out_first", out_first, e.first);
          checkOutput("out_last", out_last, e.last);
`ifdef ONLINE_ADD_NEGZERO_CHK_EN
          checkOutput("frame_err", frame_err, e.err);
`endif
          if (out_first) accum = 0;
          accum = accum * R + decDigit(dout);
          if (e.last) checkOutput("value", accum, e.total);
        end
      end
      prevStall = out_valid && !out_ready;
      prevDout  = dout;
      prevFirst = out_first;
      prevLast  = out_last;
    end
  end

  initial begin
    int waits;
    int spins;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_out_first", out_first, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    setFrame('{3, 3, 3, 3}, '{1, 0, 0, 0});
    buildExpected(0, 0);
    applyStimulus(N, 0, 0, 0, waits);
    checkOutput("first_frame_waits", waits, 0);
    setFrame('{-3, -3, 0, 0}, '{-3, 0, 0, 0});
    buildExpected(0, 0);
    applyStimulus(N, 0, 0, 0, waits);
    checkOutput("b2b_bubble", waits, 1);
    setFrame('{1, 0, 0, 0}, '{1, 0, 0, 0});
    buildExpected(0, 1);
    applyStimulus(N, 0, 1, 0, waits);
    setFrame('{0, 0, 0, 0}, '{0, 0, 0, 0});
    buildExpected(1, 0);
    applyStimulus(N, 1, 0, 0, waits);

    $display("[TB] mid-frame stall");
    setFrame('{2, -1, 3, -2}, '{1, 3, -3, 2});
    buildExpected(1, 0);
    fork
      applyStimulus(N, 1, 0, 0, waits);
      begin
        repeat (2) @(posedge clk);
        readyMode = 2;
        repeat (3) @(posedge clk);
        readyMode = 0;
      end
    join

    $display("[TB] reset mid-frame");
    repeat (3) @(posedge clk); #1;
    setFrame('{3, 2, 1, 0}, '{-2, 1, 0, 3});
    buildExpected(0, 0);
    applyStimulus(2, 0, 0, 0, waits);
    rst_n = 1'b0;
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    setFrame('{-1, 2, -3, 1}, '{2, 2, -1, -3});
    buildExpected(1, 1);
    applyStimulus(N, 1, 1, 0, waits);

    $display("[TB] random frames");
    readyMode = 1;
    for (int f = 0; f < 40; f++) begin
      bit c, s;
      for (int j = 0; j < N; j++) begin
        curA[j] = int'($urandom_range(0, 2 * (R - 1))) - (R - 1);
        curB[j] = int'($urandom_range(0, 2 * (R - 1))) - (R - 1);
        negA[j] = ($urandom_range(0, 3) == 0);
        negB[j] = ($urandom_range(0, 3) == 0);
      end
      c = 1'($urandom);
      s = 1'($urandom);
      buildExpected(c, s);
      applyStimulus(N, c, s, 1, waits);
    end

    readyMode = 0;
    spins = 0;
    while (expQ.size() != 0 && spins < 500) begin
      @(posedge clk);
      spins++;
    end
    checkOutput("drain", expQ.size(), 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
